// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and iterative-unit modes for the sequential ALU.
// Legacy opcodes list the don't-care bit 3 as 0 where it is ignored.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0100;
    localparam logic [3:0] OP_AND    = 4'b0001;
    localparam logic [3:0] OP_OR     = 4'b0101;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_LUI    = 4'b0110;
    localparam logic [3:0] OP_SLL    = 4'b0011;
    localparam logic [3:0] OP_SRL    = 4'b0111;
    localparam logic [3:0] OP_SRA    = 4'b1111;
    localparam logic [3:0] OP_POPCNT = 4'b1011;
    localparam logic [4:0] OP_MULU   = 5'b10000;
    localparam logic [4:0] OP_DIVU   = 5'b10001;

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic {MODE_MUL, MODE_DIV} iter_mode_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-read stage and the ALU.
// master = requester/writeback side, slave = alu_seq.
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       operation;
    logic [WIDTH-1:0] parameter1;
    logic [WIDTH-1:0] parameter2;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             div_by_zero;

    modport master (output in_valid, operation, parameter1, parameter2,
                    input  in_ready, out_valid, result, result_hi, zero, div_by_zero);
    modport slave  (input  in_valid, operation, parameter1, parameter2,
                    output in_ready, out_valid, result, result_hi, zero, div_by_zero);
endinterface

// File: rtl/alu_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Latency: WIDTH iterations after start; done marks the edge of the final one.
// Backpressure: none; start is only legal while idle (guaranteed by the caller).
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  iter_mode_t       mode,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             done,
    output logic [WIDTH-1:0] lo_nxt,
    output logic [WIDTH-1:0] hi_nxt,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    iter_mode_t       mode_q, mode_d;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        acc_d  = acc_q;
        sr_d   = sr_q;
        opb_d  = opb_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        mode_d = mode_q;
        sum    = {1'b0, acc_q} + {1'b0, opb_q};
        trial  = {acc_q, sr_q[WIDTH-1]};
        ge     = trial >= {1'b0, opb_q};
        diff   = trial - {1'b0, opb_q};
        done   = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

        if (start) begin
            acc_d  = '0;
            sr_d   = opa;
            opb_d  = opb;
            cnt_d  = '0;
            busy_d = 1'b1;
            mode_d = mode;
        end else if (busy_q) begin
            if (mode_q == MODE_MUL) begin
                // {acc, sr} is the running product, shifted right each step.
                if (sr_q[0]) {acc_d, sr_d} = {sum, sr_q[WIDTH-1:1]};
                else         {acc_d, sr_d} = {1'b0, acc_q, sr_q[WIDTH-1:1]};
            end else begin
                // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
                sr_d  = {sr_q[WIDTH-2:0], ge};
                acc_d = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            end
            cnt_d = cnt_q + 1'b1;
            if (done) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            sr_q   <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            mode_q <= MODE_MUL;
        end else begin
            acc_q  <= acc_d;
            sr_q   <= sr_d;
            opb_q  <= opb_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            mode_q <= mode_d;
        end
    end

    assign lo_nxt      = sr_d;
    assign hi_nxt      = acc_d;
    assign div_by_zero = (mode_q == MODE_DIV) && (opb_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with legacy ops, POPCNT and iterative MULU/DIVU.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MULU/DIVU.
// Backpressure: in_ready low while an iterative op runs; out_valid cannot be stalled.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clock,
    input  logic      resetn,
    alu_seq_if.slave  io
);
    import alu_pkg::*;

    localparam int SHAMT_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             rdy_q, rdy_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             is_iter;
    logic             start;
    iter_mode_t       iter_mode;
    logic             iter_done;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;
    logic             iter_dbz;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] pop;
    logic [SHAMT_W-1:0] shamt;

    assign accept    = io.in_valid && io.in_ready;
    assign is_iter   = (io.operation == OP_MULU) || (io.operation == OP_DIVU);
    assign iter_mode = (io.operation == OP_DIVU) ? MODE_DIV : MODE_MUL;
    assign shamt     = io.parameter1[SHAMT_W-1:0];

    always_comb begin
        pop     = '0;
        alu_res = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + {{(WIDTH-1){1'b0}}, io.parameter1[i]};
        // Extended opcodes other than MULU/DIVU fall through to zero.
        if (!io.operation[4]) begin
            case (io.operation[2:0])
                OP_ADD[2:0]: alu_res = io.parameter1 + io.parameter2;
                OP_SUB[2:0]: alu_res = io.parameter1 - io.parameter2;
                OP_AND[2:0]: alu_res = io.parameter1 & io.parameter2;
                OP_OR[2:0]:  alu_res = io.parameter1 | io.parameter2;
                OP_XOR[2:0]: alu_res = io.parameter1 ^ io.parameter2;
                OP_LUI[2:0]: alu_res = io.parameter2 << (WIDTH / 2);
                OP_SLL[2:0]: alu_res = (io.operation[3:0] == OP_POPCNT) ? pop
                                                                      : io.parameter2 << shamt;
                OP_SRL[2:0]: alu_res = (io.operation[3:0] == OP_SRA)
                                     ? $unsigned($signed(io.parameter2) >>> shamt)
                                     : io.parameter2 >> shamt;
                default:     alu_res = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        rdy_d       = 1'b1;
        out_valid_d = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        start       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_iter) begin
                        start   = 1'b1;
                        state_d = RUN;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        result_hi_d = '0;
                        zero_d      = (alu_res == '0);
                        dbz_d       = 1'b0;
                    end
                end
            end
            RUN: begin
                if (iter_done) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    result_d    = iter_lo;
                    result_hi_d = iter_hi;
                    zero_d      = (iter_lo == '0);
                    dbz_d       = iter_dbz;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
        end
    end

    alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk         (clock),
        .rst_n       (resetn),
        .start       (start),
        .mode        (iter_mode),
        .opa         (io.parameter1),
        .opb         (io.parameter2),
        .done        (iter_done),
        .lo_nxt      (iter_lo),
        .hi_nxt      (iter_hi),
        .div_by_zero (iter_dbz)
    );

    assign io.in_ready    = rdy_q && (state_q == IDLE);
    assign io.out_valid   = out_valid_q;
    assign io.result      = result_q;
    assign io.result_hi   = result_hi_q;
    assign io.zero        = zero_q;
    assign io.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq with a queue scoreboard and an independent output monitor.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    alu_seq_if #(.WIDTH(W)) io();

    alu_seq #(.WIDTH(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .io     (io)
    );

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Raises in_valid, holds it until in_ready, then records the expected response.
    task automatic send(input string name, input logic [4:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input logic [W-1:0] h,
                        input logic z, input logic d, output int waited);
        int lat;
        @(negedge clock);
        io.in_valid   = 1'b1;
        io.operation  = op;
        io.parameter1 = a;
        io.parameter2 = b;
        waited = 0;
        while (!io.in_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!io.in_ready) begin
            chk({name, " accept timeout"}, 0, 1);
            io.in_valid = 1'b0;
            return;
        end
        lat = (op == OP_MULU || op == OP_DIVU) ? W : 0;
        sb.push_back('{name, r, h, z, d, cyc + 1 + lat});
        @(posedge clock);
        #1 io.in_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (resetn && io.out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, " result"},    io.result, e.res);
                    chk({e.name, " result_hi"}, io.result_hi, e.hi);
                    chk({e.name, " zero"},      W'(io.zero), W'(e.z));
                    chk({e.name, " div0"},      W'(io.div_by_zero), W'(e.dbz));
                    chk({e.name, " cycle"},     W'(cyc), W'(e.cyc));
                end
            end
        end
    end

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
        chk({name, " drain"}, W'(sb.size()), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int w;
        io.in_valid   = 1'b0;
        io.operation  = '0;
        io.parameter1 = '0;
        io.parameter2 = '0;
        #1;
        chk("rst out_valid", W'(io.out_valid), 0);
        chk("rst in_ready",  W'(io.in_ready), 0);
        chk("rst result",    io.result, 0);
        chk("rst result_hi", io.result_hi, 0);
        chk("rst zero",      W'(io.zero), 0);
        chk("rst div0",      W'(io.div_by_zero), 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        send("add wrap", 5'b00000, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0, w);
        @(negedge clock);
        chk("add in_ready held", W'(io.in_ready), 1);
        send("popcnt",   5'b01011, 32'h80000001, 32'h0, 32'h2, 32'h0, 1'b0, 1'b0, w);
        send("sra",      5'b01111, 32'h24, 32'h80000000, 32'hF8000000, 32'h0, 1'b0, 1'b0, w);
        send("srl",      5'b00111, 32'h4, 32'h80000000, 32'h08000000, 32'h0, 1'b0, 1'b0, w);
        send("sll",      5'b00011, 32'h21, 32'h40000001, 32'h80000002, 32'h0, 1'b0, 1'b0, w);
        send("and",      5'b01001, 32'hF0F0, 32'hFF00, 32'hF000, 32'h0, 1'b0, 1'b0, w);
        send("or",       5'b00101, 32'hF0F0, 32'hFF00, 32'hFFF0, 32'h0, 1'b0, 1'b0, w);
        send("xor",      5'b00010, 32'hF0F0, 32'hFF00, 32'h0FF0, 32'h0, 1'b0, 1'b0, w);
        send("lui",      5'b00110, 32'h0, 32'h1234, 32'h12340000, 32'h0, 1'b0, 1'b0, w);
        send("sub neg",  5'b00100, 32'h3, 32'h5, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, w);
        send("ext nop",  5'b10010, 32'h5, 32'h6, 32'h0, 32'h0, 1'b1, 1'b0, w);
        send("mulu max", 5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b0, 1'b0, w);
        send("mulu x16", 5'b10000, 32'h12345678, 32'h10, 32'h23456780, 32'h1, 1'b0, 1'b0, w);
        send("divu",     5'b10001, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, w);
        send("divu 0",   5'b10001, 32'h1234, 32'h0, 32'hFFFFFFFF, 32'h1234, 1'b0, 1'b1, w);
        drain("main");

        send("mulu rst", 5'b10000, 32'd7, 32'd9, 32'd63, 32'h0, 1'b0, 1'b0, w);
        repeat (10) @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("midrst out_valid", W'(io.out_valid), 0);
        chk("midrst result",    io.result, 0);
        chk("midrst result_hi", io.result_hi, 0);
        chk("midrst div0",      W'(io.div_by_zero), 0);
        sb.delete();
        @(negedge clock);
        resetn = 1'b1;
        send("add post rst", 5'b00000, 32'd3, 32'd4, 32'd7, 32'h0, 1'b0, 1'b0, w);
        drain("reset");

        send("mulu b2b", 5'b10000, 32'd3, 32'd5, 32'd15, 32'h0, 1'b0, 1'b0, w);
        send("sub b2b",  5'b00100, 32'd5, 32'd5, 32'h0, 32'h0, 1'b1, 1'b0, w);
        chk("b2b stall cycles", W'(w), W);
        drain("b2b");
        repeat (5) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
